// File: rtl/tt_inv_test_pkg.sv
// Shared definitions for the inverter delay tester.
//   - state_e   : measurement FSM states
//   - Sel*      : result-select codes driven on ui_in[4:2]
//   - HALF_UNIT : half-period granularity in clock cycles
//   - DELAY_MAX : saturation value of the delay counter
//   - MIN_RST   : reset/clear value of the MIN register
package tt_inv_test_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StDrive  = 2'd1,
      StWait   = 2'd2,
      StSettle = 2'd3
   } state_e;

   localparam logic [2:0] SelLast   = 3'd0;
   localparam logic [2:0] SelMin    = 3'd1;
   localparam logic [2:0] SelMax    = 3'd2;
   localparam logic [2:0] SelEdges  = 3'd3;
   localparam logic [2:0] SelErr    = 3'd4;
   localparam logic [2:0] SelStatus = 3'd5;

   localparam int unsigned HALF_UNIT = 32;
   localparam logic [7:0]  DELAY_MAX = 8'd255;
   localparam logic [7:0]  MIN_RST   = 8'hFF;

   // 8-bit increment that sticks at 255.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/inv_test_sync.sv
// Multi-flop synchroniser for the asynchronous inverter response.
//   clk   : clock
//   rst_n : asynchronous active-low reset (clears every stage)
//   din   : asynchronous input
//   dout  : synchronised output, Depth cycles behind din
module inv_test_sync #(
   parameter int unsigned Depth = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic [Depth-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[Depth-2:0], din};
      end
   end

   assign dout = sync_q[Depth-1];

endmodule

// File: rtl/tt_um_inverter_tester.sv
// Inverter propagation-delay tester. Toggles STIM every half period, times how long the
// external inverter takes to answer (through a 2-flop synchroniser), and keeps statistics.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : design enabled; low forces the FSM back to idle
//   ui_in      : [0] RESP, [1] RUN, [4:2] SEL, [7:5] half-period code HPC
//   uo_out     : registered result byte chosen by SEL
//   uio_in     : unused
//   uio_out    : [0] STIM, [1] busy, [2] timeout flag, [3] error flag, [7:4] zero
//   uio_oe     : constant 8'h0F
// Optional MIN/MAX delay tracking is built when INVTEST_MINMAX_EN is defined; otherwise
// SEL 1 and 2 read zero.
module tt_um_inverter_tester
   import tt_inv_test_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic       resp, run;
   logic [2:0] sel, hpc;
   logic       sresp;

   assign resp = ui_in[0];
   assign run  = ui_in[1];
   assign sel  = ui_in[4:2];
   assign hpc  = ui_in[7:5];

   logic unused_uio;
   assign unused_uio = ^uio_in;

   inv_test_sync #(
      .Depth(2)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (resp),
      .dout (sresp)
   );

   state_e     state_q, state_d;
   logic       stim_q, stim_d;
   logic [7:0] delay_q, delay_d;
   logic [8:0] hp_q, hp_d;
   logic [7:0] edges_q, edges_d;
   logic [7:0] last_q, last_d;
   logic [7:0] err_q, err_d;
   logic       to_flag_q, to_flag_d;
   logic       err_flag_q, err_flag_d;
   logic       err_seen_q, err_seen_d;
   logic       run_q;
   logic [7:0] out_q, out_d;

   logic       busy, resp_ok, hp_expire;
   logic       meas_valid, stats_clr;
   logic [7:0] min_val, max_val;

   assign busy    = (state_q != StIdle);
   assign resp_ok = (sresp == ~stim_q);
   // The DRIVE cycle already used one cycle of the half period, so the count of
   // (HPC+1)*HALF_UNIT runs out when it reaches 2.
   assign hp_expire = (hp_q <= 9'd2);

   always_comb begin
      state_d    = state_q;
      stim_d     = stim_q;
      delay_d    = delay_q;
      hp_d       = hp_q;
      edges_d    = edges_q;
      last_d     = last_q;
      err_d      = err_q;
      to_flag_d  = to_flag_q;
      err_flag_d = err_flag_q;
      err_seen_d = err_seen_q;
      meas_valid = 1'b0;
      stats_clr  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (ena && run) begin
               state_d = StDrive;
               // Fresh RUN request: start statistics from scratch.
               if (!run_q) begin
                  stats_clr  = 1'b1;
                  err_d      = 8'd0;
                  edges_d    = 8'd0;
                  to_flag_d  = 1'b0;
                  err_flag_d = 1'b0;
               end
            end
         end
         StDrive: begin
            stim_d     = ~stim_q;
            delay_d    = 8'd0;
            hp_d       = 9'((32'(hpc) + 32'd1) * HALF_UNIT);
            edges_d    = edges_q + 8'd1;
            err_seen_d = 1'b0;
            state_d    = StWait;
         end
         StWait: begin
            hp_d = hp_q - 9'd1;
            if (delay_q != DELAY_MAX) begin
               delay_d = delay_q + 8'd1;
            end
            if (resp_ok) begin
               last_d     = delay_q;
               meas_valid = 1'b1;
               state_d    = StSettle;
            end else if (hp_expire) begin
               to_flag_d = 1'b1;
               err_d     = sat_inc(err_q);
               state_d   = run ? StDrive : StIdle;
            end
         end
         StSettle: begin
            hp_d = hp_q - 9'd1;
            if (!resp_ok) begin
               err_flag_d = 1'b1;
               if (!err_seen_q) begin
                  err_d      = sat_inc(err_q);
                  err_seen_d = 1'b1;
               end
            end
            if (hp_expire) begin
               state_d = run ? StDrive : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (!ena) begin
         state_d = StIdle;
      end
   end

`ifdef INVTEST_MINMAX_EN
   logic [7:0] min_q, min_d, max_q, max_d;

   always_comb begin
      min_d = min_q;
      max_d = max_q;
      if (stats_clr) begin
         min_d = MIN_RST;
         max_d = 8'd0;
      end else if (meas_valid) begin
         if (delay_q < min_q) min_d = delay_q;
         if (delay_q > max_q) max_d = delay_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_q <= MIN_RST;
         max_q <= 8'd0;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
      end
   end

   assign min_val = min_q;
   assign max_val = max_q;
`else
   logic unused_mm;
   assign unused_mm = meas_valid ^ stats_clr;
   assign min_val   = 8'h00;
   assign max_val   = 8'h00;
`endif

   always_comb begin
      out_d = 8'h00;
      case (sel)
         SelLast:   out_d = last_q;
         SelMin:    out_d = min_val;
         SelMax:    out_d = max_val;
         SelEdges:  out_d = edges_q;
         SelErr:    out_d = err_q;
         SelStatus: out_d = {4'b0000, err_flag_q, to_flag_q, busy, stim_q};
         default:   out_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         stim_q     <= 1'b0;
         delay_q    <= 8'd0;
         hp_q       <= 9'd0;
         edges_q    <= 8'd0;
         last_q     <= 8'd0;
         err_q      <= 8'd0;
         to_flag_q  <= 1'b0;
         err_flag_q <= 1'b0;
         err_seen_q <= 1'b0;
         run_q      <= 1'b0;
         out_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         stim_q     <= stim_d;
         delay_q    <= delay_d;
         hp_q       <= hp_d;
         edges_q    <= edges_d;
         last_q     <= last_d;
         err_q      <= err_d;
         to_flag_q  <= to_flag_d;
         err_flag_q <= err_flag_d;
         err_seen_q <= err_seen_d;
         run_q      <= run;
         out_q      <= out_d;
      end
   end

   assign uo_out  = out_q;
   assign uio_out = {4'b0000, err_flag_q, to_flag_q, busy, stim_q};
   assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_inverter_tester.sv
// Bench for tt_um_inverter_tester: models the external inverter as a loopback with a
// programmable delay (or a constant level), runs directed and randomised measurements and
// compares every result register against values derived from the delay/half-period rules.
module tb_tt_um_inverter_tester;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

   logic       run, glitch, mode_const, const_val;
   logic [2:0] sel, hpc;
   int         dly;
   logic [63:0] hist = '0;
   logic       resp_w;
   logic       model_stim;
   int         n_cmp, n_fail, busy_low;

   tt_um_inverter_tester dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .ui_in  (ui_in),
      .uo_out (uo_out),
      .uio_in (uio_in),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Loopback inverter: response follows ~STIM exactly dly clock cycles later.
   always @(posedge clk) hist <= {hist[62:0], uio_out[0]};
   assign resp_w = (mode_const ? const_val
                               : ((dly == 0) ? ~uio_out[0] : ~hist[6'(dly - 1)])) ^ glitch;
   assign ui_in  = {hpc, sel, run, resp_w};
   assign uio_in = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_mm(input logic [7:0] v);
`ifdef INVTEST_MINMAX_EN
      return v;
`else
      return 8'h00;
`endif
   endfunction

   function automatic logic [7:0] status_exp(input logic ef, input logic tf);
      return {4'b0000, ef, tf, 1'b0, model_stim};
   endfunction

   task automatic read_sel(input logic [2:0] s, output logic [7:0] v);
      sel = s;
      @(posedge clk);
      #1;
      v = uo_out;
   endtask

   task automatic check_results(input string name, input logic [7:0] e_last,
                                input logic [7:0] e_min, input logic [7:0] e_max,
                                input logic [7:0] e_edges, input logic [7:0] e_err,
                                input logic [7:0] e_status);
      logic [7:0] v;
      read_sel(3'd0, v); check({name, ".last"}, v, e_last);
      read_sel(3'd1, v); check({name, ".min"}, v, e_min);
      read_sel(3'd2, v); check({name, ".max"}, v, e_max);
      read_sel(3'd3, v); check({name, ".edges"}, v, e_edges);
      read_sel(3'd4, v); check({name, ".err"}, v, e_err);
      read_sel(3'd5, v); check({name, ".status"}, v, e_status);
   endtask

   task automatic wait_toggle(input int bound, output int cyc);
      logic s0;
      s0  = uio_out[0];
      cyc = 0;
      while (uio_out[0] === s0 && cyc < bound) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("toggle_seen", {31'd0, uio_out[0] !== s0}, 32'd1);
   endtask

   task automatic wait_idle(input int bound);
      int cyc;
      cyc = 0;
      while (uio_out[1] === 1'b1 && cyc < bound) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("idle_reached", {31'd0, uio_out[1]}, 32'd0);
   endtask

   // Raise RUN, let 'halves' half periods start, drop RUN mid-way through the last one.
   task automatic do_run(input int halves, input int n);
      int cyc;
      run = 1'b1;
      wait_toggle(8, cyc);
      check("first_toggle", cyc, 32'd2);
      for (int h = 1; h < halves; h++) begin
         if (uio_out[1] !== 1'b1) busy_low++;
         wait_toggle(n + 4, cyc);
         check("half_period", cyc, n);
      end
      if (uio_out[1] !== 1'b1) busy_low++;
      repeat (n / 2) @(posedge clk);
      #1 run = 1'b0;
      wait_idle(n + 4);
      if (halves % 2 == 1) model_stim = ~model_stim;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         cyc, halves, e_to;
      logic [7:0] v, s;

      n_cmp = 0; n_fail = 0; busy_low = 0;
      rst_n = 1'b0; ena = 1'b1; run = 1'b0; glitch = 1'b0;
      mode_const = 1'b0; const_val = 1'b0; sel = 3'd0; hpc = 3'd0; dly = 0;
      model_stim = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst.uo_out", uo_out, 8'h00);
      check("rst.uio_out", uio_out, 8'h00);
      check("rst.uio_oe", uio_oe, 8'h0F);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_results("rst", 8'd0, exp_mm(8'hFF), 8'd0, 8'd0, 8'd0, 8'd0);
      read_sel(3'd6, v);
      check("sel6", v, 8'h00);

      // Zero-delay loopback: LAST = 2, 64-cycle STIM period
      do_run(4, 32);
      check_results("loop0", 8'd2, exp_mm(8'd2), exp_mm(8'd2), 8'd4, 8'd0, status_exp(0, 0));

      // 10-cycle loopback
      dly = 10;
      repeat (64) @(posedge clk);
      #1;
      do_run(3, 32);
      check_results("loop10", 8'd12, exp_mm(8'd12), exp_mm(8'd12), 8'd3, 8'd0,
                    status_exp(0, 0));

      // Delay switched from 5 to 20 right after a STIM edge
      dly = 5;
      repeat (64) @(posedge clk);
      #1;
      run = 1'b1;
      wait_toggle(8, cyc);
      wait_toggle(36, cyc);
      dly = 20;
      wait_toggle(36, cyc);
      repeat (16) @(posedge clk);
      #1 run = 1'b0;
      wait_idle(36);
      model_stim = ~model_stim;
      check_results("switch", 8'd22, exp_mm(8'd7), exp_mm(8'd22), 8'd3, 8'd0,
                    status_exp(0, 0));

      // Randomised delays and half periods
      for (int i = 0; i < 3; i++) begin
         dly    = int'($urandom_range(0, 20));
         hpc    = 3'($urandom_range(0, 2));
         halves = int'($urandom_range(2, 4));
         repeat (64) @(posedge clk);
         #1;
         do_run(halves, (int'(hpc) + 1) * 32);
         check_results("rand", 8'(dly + 2), exp_mm(8'(dly + 2)), exp_mm(8'(dly + 2)),
                       8'(halves), 8'd0, status_exp(0, 0));
      end

      // ena low mid-SETTLE forces idle and keeps the result
      dly = 2; hpc = 3'd0;
      repeat (64) @(posedge clk);
      #1 run = 1'b1;
      wait_toggle(8, cyc);
      repeat (10) @(posedge clk);
      #1 ena = 1'b0;
      @(posedge clk);
      #1;
      check("ena_busy", {31'd0, uio_out[1]}, 32'd0);
      run = 1'b0;
      @(posedge clk);
      #1 ena = 1'b1;
      model_stim = ~model_stim;
      check_results("ena", 8'd4, exp_mm(8'd4), exp_mm(8'd4), 8'd1, 8'd0, status_exp(0, 0));

      // Single-cycle RESP glitches during SETTLE: two in one half period count once
      dly = 3;
      repeat (64) @(posedge clk);
      #1 run = 1'b1;
      wait_toggle(8, cyc);
      wait_toggle(36, cyc);
      repeat (12) @(posedge clk);
      #1 glitch = 1'b1;
      @(posedge clk);
      #1 glitch = 1'b0;
      repeat (7) @(posedge clk);
      #1 glitch = 1'b1;
      @(posedge clk);
      #1 glitch = 1'b0;
      wait_toggle(36, cyc);
      repeat (12) @(posedge clk);
      #1 glitch = 1'b1;
      @(posedge clk);
      #1 glitch = 1'b0;
      repeat (3) @(posedge clk);
      #1 run = 1'b0;
      wait_idle(36);
      model_stim = ~model_stim;
      check_results("glitch", 8'd5, exp_mm(8'd5), exp_mm(8'd5), 8'd3, 8'd2, status_exp(1, 0));

      // RESP tied high for 4 full STIM periods: every half period driving STIM=1 times out
      mode_const = 1'b1; const_val = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      e_to = 0;
      s    = {7'd0, model_stim};
      for (int h = 0; h < 8; h++) begin
         s[0] = ~s[0];
         if (const_val == s[0]) e_to++;
      end
      busy_low = 0;
      do_run(8, 32);
      check("tied.busy_hold", busy_low, 32'd0);
      check_results("tied", 8'd0, exp_mm(8'd0), exp_mm(8'd0), 8'd8, 8'(e_to),
                    status_exp(0, e_to != 0));

      // Reset pulse mid-WAIT, then a clean measurement
      mode_const = 1'b0; dly = 40; hpc = 3'd3;
      repeat (64) @(posedge clk);
      #1 run = 1'b1;
      wait_toggle(8, cyc);
      sel = 3'd5;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_async.uo_out", uo_out, 8'h00);
      check("rst_async.uio_out", uio_out, 8'h00);
      @(posedge clk);
      #1;
      run = 1'b0;
      rst_n = 1'b1;
      model_stim = 1'b0;
      repeat (64) @(posedge clk);
      #1;
      check_results("post_rst", 8'd0, exp_mm(8'hFF), 8'd0, 8'd0, 8'd0, 8'd0);
      do_run(2, 128);
      check_results("after_rst", 8'd42, exp_mm(8'd42), exp_mm(8'd42), 8'd2, 8'd0,
                    status_exp(0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/tt_um_inverter_tester.md
TT_UM_INVERTER_TESTER -- requirements
Module: tt_um_inverter_tester

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  high while the design is enabled.
- ui_in  input  8  [0] inverter response (RESP), [1] RUN, [4:2] result select (SEL), [7:5] half-period code (HPC).
- uo_out  output  8  selected result byte.
- uio_in  input  8  unused and ignored.
- uio_out  output  8  [0] stimulus (STIM), [1] busy, [2] timeout flag, [3] error flag, [7:4] = 0.
- uio_oe  output  8  constant 8'h0F.

Function
REQ-002 RESP SHALL pass through a 2-flop synchroniser (SRESP) before any use.
REQ-003 The FSM SHALL have the states IDLE, DRIVE, WAIT and SETTLE.
REQ-004 IDLE: STIM holds its value and busy=0; the FSM goes to DRIVE when RUN=1 and ena=1.
REQ-005 DRIVE (1 cycle): STIM toggles, the delay counter clears, the half-period counter loads (HPC+1)*32, the edge counter increments (8-bit, wrapping), and the FSM goes to WAIT.
REQ-006 WAIT: the delay counter increments each cycle, saturating at 255.
REQ-007 WAIT: on the first cycle where SRESP equals ~STIM, LAST is set to the delay and the FSM goes to SETTLE.
REQ-008 Delay is measured so that a zero-delay external inverter loopback yields LAST=2.
REQ-009 WAIT: if the half-period counter expires first, the timeout flag is set (sticky), ERR increments (saturating at 255) and LAST is left unchanged.
REQ-010 On a timeout, DRIVE follows directly if RUN=1, otherwise IDLE.
REQ-011 SETTLE: if SRESP differs from ~STIM in any cycle, ERR increments once per half period (saturating at 255) and the error flag is set (sticky).
REQ-012 SETTLE: on half-period expiry the FSM goes to DRIVE if RUN=1, otherwise IDLE.
REQ-013 Dropping RUN while in WAIT or SETTLE SHALL NOT abort the current half period.
REQ-014 ena=0 SHALL force the FSM to IDLE on the next clock; results and flags are retained.
REQ-015 A rising edge of RUN, detected in IDLE, SHALL clear ERR, both flags, MIN/MAX and the edge counter before DRIVE.
REQ-016 uo_out by SEL: 0=LAST, 1=MIN, 2=MAX, 3=edge count, 4=ERR, 5={4'b0, err flag, timeout flag, busy, STIM}, 6-7=8'h00.
REQ-017 uo_out SHALL be registered, giving 1 cycle latency from a SEL or value change.
REQ-018 busy SHALL be 1 in DRIVE, WAIT and SETTLE.

Reset
REQ-019 While rst_n=0 the block SHALL hold: STIM=0, FSM=IDLE, LAST=0, ERR=0, edge count=0, flags=0, MIN=8'hFF, MAX=0, synchroniser=0, uo_out=0.
REQ-020 Reset asserted mid-WAIT SHALL produce the REQ-019 values immediately (asynchronous), with no partial result recorded.

Configuration
REQ-021 With INVTEST_MINMAX_EN defined, every successful WAIT SHALL update MIN=min(MIN,LAST) and MAX=max(MAX,LAST).
REQ-022 Without INVTEST_MINMAX_EN, the MIN/MAX registers SHALL be absent and SEL 1 and 2 SHALL read 8'h00.

Structure
REQ-023 The package tt_inv_test_pkg SHALL hold the state enum, SEL codes, HALF_UNIT=32, DELAY_MAX=255 and the reset constant MIN_RST=8'hFF.
REQ-024 The synchroniser SHALL be a sub-module named inv_test_sync (parameterised depth, default 2).

Verification
REQ-025 Zero-delay loopback uio_out[0] -> ~ -> ui_in[0], HPC=0, RUN=1 -> LAST=2, STIM period 64 cycles, ERR=0, flags=0.
REQ-026 Loopback with 10-cycle model delay -> LAST=12; with the macro, MIN=MAX=12.
REQ-027 Delay 5 cycles then switched to 20 -> with the macro, MIN=7 and MAX=22; without it, SEL1/SEL2 read 0.
REQ-028 RESP tied to 1, HPC=0, 4 full STIM periods -> ERR=4, timeout flag=1, busy=1 throughout.
REQ-029 1-cycle pulse injected on RESP during SETTLE -> ERR increments by exactly 1, error flag=1, LAST unchanged.
REQ-030 rst_n low for 1 cycle mid-WAIT -> all REQ-019 values, SEL1 reads 8'hFF with the macro, and a new measurement starts correctly after RUN is re-asserted.
